// File: rtl/memory_access_pkg.sv
// Shared types for the MEM stage: bus sizes, decoded ops, pipeline register layouts
// and the op-classification helpers used by the stage and its lane aligner.
package memory_access_pkg;

    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [4:0] {
        OP_NOP, OP_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef struct packed {
        logic         valid;
        logic [31:0]  inst;
        word_t        inst_pc;
        op_t          op;
        word_t        alu_result;
        word_t        write_mem_data;
        logic [63:0]  inst_counter;
        logic         jump;
    } ex_mem_t;

    typedef struct packed {
        logic         valid;
        logic [31:0]  inst;
        word_t        inst_pc;
        op_t          op;
        logic [63:0]  inst_counter;
        logic         reg_write_enable;
        reg_addr_t    reg_dest_addr;
        word_t        reg_write_data;
    } mem_wb_t;

    typedef struct packed {
        logic         reg_write_enable;
        reg_addr_t    reg_dest_addr;
        word_t        reg_write_data;
    } reg_writer_t;

    function automatic logic is_load(input op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD) ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
    endfunction

    function automatic logic is_store(input op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
    endfunction

    function automatic logic writes_rd(input op_t op);
        return (op == OP_ALU) || (op == OP_LUI) || (op == OP_AUIPC) ||
               (op == OP_JAL) || (op == OP_JALR) || is_load(op);
    endfunction

    function automatic msize_t op_size(input op_t op);
        msize_t size;
        size = MSIZE8;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = MSIZE1;
            OP_LH, OP_LHU, OP_SH: size = MSIZE2;
            OP_LW, OP_LWU, OP_SW: size = MSIZE4;
            default:              size = MSIZE8;
        endcase
        return size;
    endfunction

    function automatic strobe_t size_mask(input msize_t size);
        strobe_t mask;
        mask = 8'hFF;
        case (size)
            MSIZE1:  mask = 8'h01;
            MSIZE2:  mask = 8'h03;
            MSIZE4:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational byte-lane logic: store strobes and data shifting, load extraction
// and sign/zero extension, all keyed by the op and the low three address bits.
module memory_access_mem_align
    import memory_access_pkg::*;
(
    input  op_t          op,
    input  logic [2:0]   offset,
    input  word_t        store_data,
    input  word_t        read_data,
    output msize_t       size,
    output strobe_t      strobe,
    output word_t        store_lanes,
    output word_t        load_data
);

    logic [5:0] shift;
    word_t      raw;

    assign size        = op_size(op);
    assign shift       = {offset, 3'b000};
    assign strobe      = is_store(op) ? strobe_t'(size_mask(size) << offset) : '0;
    assign store_lanes = store_data << shift;
    assign raw         = read_data >> shift;

    // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
    always_comb begin
        load_data = raw;
        case (op)
            OP_LB:   load_data = {{56{raw[7]}},  raw[7:0]};
            OP_LH:   load_data = {{48{raw[15]}}, raw[15:0]};
            OP_LW:   load_data = {{32{raw[31]}}, raw[31:0]};
            OP_LBU:  load_data = {56'd0, raw[7:0]};
            OP_LHU:  load_data = {48'd0, raw[15:0]};
            OP_LWU:  load_data = {32'd0, raw[31:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the RV64 pipeline: issues dbus requests, stalls via ok, builds mem_wb
// and the EX bypass. Define MEM_STALL_COUNT_EN to add the stall_cycles counter output.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  ex_mem_t            ex_mem_state,
    input  logic               step,
    output mem_wb_t            mem_wb_state,
    output reg_writer_t        forward,
    output logic               ok,
    output logic               dreq_valid,
    output logic [ADDR_W-1:0]  dreq_addr,
    output msize_t             dreq_size,
    output strobe_t            dreq_strobe,
    output logic [DATA_W-1:0]  dreq_data,
    input  logic               dresp_addr_ok,
    input  logic               dresp_data_ok,
    input  logic [DATA_W-1:0]  dresp_data
`ifdef MEM_STALL_COUNT_EN
    ,
    output logic [63:0]        stall_cycles
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    word_t      load_buf;
    word_t      load_data;
    word_t      store_lanes;
    logic       mem_op;
    logic       issuing;
    logic       capture;
    logic       unused_bits;

    assign mem_op  = ex_mem_state.valid && (is_load(ex_mem_state.op) || is_store(ex_mem_state.op));
    assign issuing = ((state == S_IDLE) && mem_op) || (state == S_WAIT);
    assign capture = issuing && dresp_data_ok;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mem_op) state_next = dresp_data_ok ? S_DONE : S_WAIT;
            S_WAIT:  if (dresp_data_ok) state_next = S_DONE;
            S_DONE:  if (step) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            load_buf <= '0;
        end else begin
            state <= state_next;
            if (capture) load_buf <= dresp_data;
        end
    end

    // Load data is always taken from load_buf, so DONE holds a stable result until step.
    memory_access_mem_align u_align (
        .op          (ex_mem_state.op),
        .offset      (ex_mem_state.alu_result[2:0]),
        .store_data  (ex_mem_state.write_mem_data),
        .read_data   (load_buf),
        .size        (dreq_size),
        .strobe      (dreq_strobe),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    assign ok         = (state == S_DONE) || ((state == S_IDLE) && !mem_op);
    assign dreq_valid = issuing;
    assign dreq_addr  = ADDR_W'(ex_mem_state.alu_result);
    assign dreq_data  = DATA_W'(store_lanes);

    always_comb begin
        mem_wb_state.valid            = ex_mem_state.valid;
        mem_wb_state.inst             = ex_mem_state.inst;
        mem_wb_state.inst_pc          = ex_mem_state.inst_pc;
        mem_wb_state.op               = ex_mem_state.op;
        mem_wb_state.inst_counter     = ex_mem_state.inst_counter;
        mem_wb_state.reg_dest_addr    = ex_mem_state.inst[11:7];
        mem_wb_state.reg_write_enable = ex_mem_state.valid && writes_rd(ex_mem_state.op) &&
                                        (ex_mem_state.inst[11:7] != 5'd0);
        mem_wb_state.reg_write_data   = is_load(ex_mem_state.op) ? load_data
                                                                 : ex_mem_state.alu_result;
    end

    // A load still in flight must never reach the bypass with stale data.
    assign forward.reg_write_enable = mem_wb_state.reg_write_enable && ok;
    assign forward.reg_dest_addr    = mem_wb_state.reg_dest_addr;
    assign forward.reg_write_data   = mem_wb_state.reg_write_data;

    assign unused_bits = ex_mem_state.jump ^ dresp_addr_ok;

    // Once issued, a request stays up until the bus accepts its address.
    assert property (@(posedge clk)
        (rst_n && dreq_valid && !dresp_addr_ok) |=> (dreq_valid || !rst_n));

`ifdef MEM_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) stall_cycles <= '0;
        else if (!ok) stall_cycles <= stall_cycles + 64'd1;
    end
`else
    // Stall instrumentation is compiled out in this build.
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for the MEM stage: passthrough, loads, stores,
// DONE hold without step, reset during an access, and writes to x0.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_mem_t     ex;
    logic        step;
    mem_wb_t     mem_wb_state;
    reg_writer_t forward;
    logic        ok;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    msize_t      dreq_size;
    strobe_t     dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    int checks = 0;
    int errors = 0;

    localparam word_t GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

    always #5 clk = ~clk;

    memory_access dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_mem_state  (ex),
        .step          (step),
        .mem_wb_state  (mem_wb_state),
        .forward       (forward),
        .ok            (ok),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    task automatic set_ex(input logic v, input op_t op, input word_t addr,
                          input word_t wdata, input logic [4:0] rd);
        ex.valid          = v;
        ex.inst           = {20'h0, rd, 7'h03};
        ex.inst_pc        = 64'h8000_0100;
        ex.op             = op;
        ex.alu_result     = addr;
        ex.write_mem_data = wdata;
        ex.inst_counter   = 64'd42;
        ex.jump           = 1'b0;
    endtask

    task automatic do_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        set_ex(1'b0, OP_NOP, 64'd0, 64'd0, 5'd0);
    endtask

    // Drives one access that completes after `waits` wait states; returns in DONE.
    task automatic run_mem(input op_t op, input word_t addr, input word_t wdata,
                           input logic [4:0] rd, input word_t rdata, input int waits);
        for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            if (c == 0) set_ex(1'b1, op, addr, wdata, rd);
            dresp_data_ok = (c == waits);
            dresp_addr_ok = (c == waits);
            dresp_data    = (c == waits) ? rdata : GARBAGE;
            #1;
            checks++; if (ok !== 1'b0) begin errors++; $display("FAIL stall_ok got=%b want=0", ok); end
            checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL stall_dreq_valid got=%b want=1", dreq_valid); end
            checks++; if (forward.reg_write_enable !== 1'b0) begin errors++; $display("FAIL stall_fwd_we got=%b want=0", forward.reg_write_enable); end
            checks++; if (dreq_addr !== addr) begin errors++; $display("FAIL stall_addr got=%h want=%h", dreq_addr, addr); end
        end
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data    = GARBAGE;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid got=%b want=0", dreq_valid); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reset_ok got=%b want=1", ok); end
        checks++; if (forward.reg_write_enable !== 1'b0) begin errors++; $display("FAIL reset_fwd_we got=%b want=0", forward.reg_write_enable); end
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        set_ex(1'b1, OP_ALU, 64'h1234, 64'd0, 5'd5);
        #1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alu_ok got=%b want=1", ok); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL alu_dreq_valid got=%b want=0", dreq_valid); end
        checks++; if (forward !== {1'b1, 5'd5, 64'h1234}) begin errors++; $display("FAIL alu_forward got=%h want=%h", forward, {1'b1, 5'd5, 64'h1234}); end
        checks++; if (mem_wb_state.inst_pc !== 64'h8000_0100 || mem_wb_state.inst_counter !== 64'd42 || mem_wb_state.valid !== 1'b1)
            begin errors++; $display("FAIL alu_passthrough got pc=%h cnt=%0d v=%b want pc=80000100 cnt=42 v=1", mem_wb_state.inst_pc, mem_wb_state.inst_counter, mem_wb_state.valid); end
        @(negedge clk);
        set_ex(1'b1, OP_JAL, 64'h8000_0104, 64'd0, 5'd1);
        #1;
        checks++; if (forward !== {1'b1, 5'd1, 64'h8000_0104}) begin errors++; $display("FAIL jal_forward got=%h want=%h", forward, {1'b1, 5'd1, 64'h8000_0104}); end
        @(negedge clk);
        set_ex(1'b1, OP_BRANCH, 64'h1, 64'd0, 5'd5);
        #1;
        checks++; if (mem_wb_state.reg_write_enable !== 1'b0) begin errors++; $display("FAIL branch_we got=%b want=0", mem_wb_state.reg_write_enable); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL branch_ok got=%b want=1", ok); end
        @(negedge clk);
        set_ex(1'b0, OP_NOP, 64'd0, 64'd0, 5'd0);
    endtask

    task automatic test_load_lb();
        run_mem(OP_LB, 64'h8000_0003, 64'd0, 5'd10, 64'h0000_0000_80FF_0000, 1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lb_ok got=%b want=1", ok); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL lb_dreq_valid got=%b want=0", dreq_valid); end
        checks++; if (dreq_size !== MSIZE1) begin errors++; $display("FAIL lb_size got=%0d want=%0d", dreq_size, MSIZE1); end
        checks++; if (forward !== {1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FF80}) begin errors++; $display("FAIL lb_forward got=%h want=%h", forward, {1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FF80}); end
        do_step();
        run_mem(OP_LBU, 64'h8000_0003, 64'd0, 5'd11, 64'h0000_0000_80FF_0000, 1);
        checks++; if (mem_wb_state.reg_write_data !== 64'h80) begin errors++; $display("FAIL lbu_data got=%h want=80", mem_wb_state.reg_write_data); end
        do_step();
    endtask

    task automatic test_load_table();
        op_t   ops  [4] = '{OP_LH, OP_LHU, OP_LW, OP_LWU};
        word_t adr  [4] = '{64'h102, 64'h102, 64'h200, 64'h204};
        word_t rd_v [4] = '{64'h0000_0000_80FF_0000, 64'h0000_0000_80FF_0000,
                            64'hFFFF_FFFF_8000_0001, 64'h8000_0001_0000_0000};
        word_t exp  [4] = '{64'hFFFF_FFFF_FFFF_80FF, 64'h0000_0000_0000_80FF,
                            64'hFFFF_FFFF_8000_0001, 64'h0000_0000_8000_0001};
        for (int i = 0; i < 4; i++) begin
            run_mem(ops[i], adr[i], 64'd0, 5'd12, rd_v[i], 0);
            checks++; if (mem_wb_state.reg_write_data !== exp[i]) begin errors++; $display("FAIL load_table[%0d] got=%h want=%h", i, mem_wb_state.reg_write_data, exp[i]); end
            do_step();
        end
    endtask

    task automatic test_store_sh();
        @(negedge clk);
        set_ex(1'b1, OP_SH, 64'h6, 64'hABCD, 5'd0);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        #1;
        checks++; if (dreq_strobe !== 8'hC0) begin errors++; $display("FAIL sh_strobe got=%h want=c0", dreq_strobe); end
        checks++; if (dreq_data !== 64'hABCD_0000_0000_0000) begin errors++; $display("FAIL sh_data got=%h want=abcd000000000000", dreq_data); end
        checks++; if (dreq_size !== MSIZE2) begin errors++; $display("FAIL sh_size got=%0d want=%0d", dreq_size, MSIZE2); end
        checks++; if (mem_wb_state.reg_write_enable !== 1'b0) begin errors++; $display("FAIL sh_we got=%b want=0", mem_wb_state.reg_write_enable); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL sh_ok_idle got=%b want=0", ok); end
        @(negedge clk);
        dresp_data_ok = 1'b1;
        dresp_addr_ok = 1'b1;
        #1;
        checks++; if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hC0) begin errors++; $display("FAIL sh_wait_hold got v=%b strb=%h want v=1 strb=c0", dreq_valid, dreq_strobe); end
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        #1;
        checks++; if (ok !== 1'b1 || dreq_valid !== 1'b0) begin errors++; $display("FAIL sh_done got ok=%b v=%b want ok=1 v=0", ok, dreq_valid); end
        do_step();
        @(negedge clk);
        set_ex(1'b1, OP_LW, 64'h20, 64'd0, 5'd3);
        #1;
        checks++; if (dreq_strobe !== 8'h00) begin errors++; $display("FAIL load_strobe got=%h want=00", dreq_strobe); end
        @(negedge clk);
        set_ex(1'b0, OP_NOP, 64'd0, 64'd0, 5'd0);
    endtask

    task automatic test_hold_done();
        run_mem(OP_LD, 64'h1000, 64'd0, 5'd7, 64'h0123_4567_89AB_CDEF, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (ok !== 1'b1 || dreq_valid !== 1'b0) begin errors++; $display("FAIL hold_done[%0d] got ok=%b v=%b want ok=1 v=0", i, ok, dreq_valid); end
            checks++; if (mem_wb_state.reg_write_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL hold_data[%0d] got=%h want=0123456789abcdef", i, mem_wb_state.reg_write_data); end
            @(negedge clk);
            #1;
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        #1;
        checks++; if (dreq_valid !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL hold_idle_after_step got v=%b ok=%b want v=1 ok=0", dreq_valid, ok); end
        dresp_data_ok = 1'b1;
        dresp_addr_ok = 1'b1;
        dresp_data    = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data    = GARBAGE;
        #1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL same_cycle_done got ok=%b want=1", ok); end
        do_step();
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        set_ex(1'b1, OP_LW, 64'h20, 64'd0, 5'd3);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (dreq_valid !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL rst_pre_wait got v=%b ok=%b want v=1 ok=0", dreq_valid, ok); end
        rst_n = 1'b0;
        set_ex(1'b0, OP_NOP, 64'd0, 64'd0, 5'd0);
        @(negedge clk);
        #1;
        checks++; if (dreq_valid !== 1'b0 || ok !== 1'b1 || forward.reg_write_enable !== 1'b0)
            begin errors++; $display("FAIL rst_wait got v=%b ok=%b we=%b want v=0 ok=1 we=0", dreq_valid, ok, forward.reg_write_enable); end
        rst_n = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_addr_ok = 1'b1;
        dresp_data    = GARBAGE;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        set_ex(1'b1, OP_LD, 64'h40, 64'd0, 5'd9);
        #1;
        checks++; if (ok !== 1'b0 || dreq_valid !== 1'b1) begin errors++; $display("FAIL rst_late_resp_ignored got ok=%b v=%b want ok=0 v=1", ok, dreq_valid); end
        dresp_data_ok = 1'b1;
        dresp_addr_ok = 1'b1;
        dresp_data    = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data    = GARBAGE;
        #1;
        checks++; if (forward !== {1'b1, 5'd9, 64'h5555_AAAA_5555_AAAA}) begin errors++; $display("FAIL rst_next_load got=%h want=%h", forward, {1'b1, 5'd9, 64'h5555_AAAA_5555_AAAA}); end
        do_step();
    endtask

    task automatic test_rd0();
        run_mem(OP_LD, 64'h8, 64'd0, 5'd0, 64'h1111_2222_3333_4444, 1);
        checks++; if (mem_wb_state.reg_write_enable !== 1'b0) begin errors++; $display("FAIL rd0_we got=%b want=0", mem_wb_state.reg_write_enable); end
        checks++; if (forward.reg_write_enable !== 1'b0) begin errors++; $display("FAIL rd0_fwd_we got=%b want=0", forward.reg_write_enable); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd0_ok got=%b want=1", ok); end
        do_step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        step          = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = GARBAGE;
        set_ex(1'b0, OP_NOP, 64'd0, 64'd0, 5'd0);
        test_reset();
        test_passthrough();
        test_load_lb();
        test_load_table();
        test_store_sh();
        test_hold_done();
        test_reset_wait();
        test_rd0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage RV64 pipeline; sits directly downstream of EX.
- Consumes the `ex_mem` pipeline register and issues load/store requests on the data bus (dbus: dreq/dresp).
- Aligns and extends load data, then produces the `mem_wb` pipeline register plus a `reg_writer` forward path back to EX.
- Holds its own `ok` low while a memory access is outstanding, which stalls the pipeline.

Parameters:
- `ADDR_W`, 64, width of dreq address.
- `DATA_W`, 64, width of dbus data; must equal `word_t`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `ex_mem_state`  in  `ex_mem`  EX/MEM register contents: valid, inst, inst_pc, op, alu_result, write_mem_data, inst_counter, jump.
- `step`  in  1  pipeline registers advance at this edge (all stages ok).
- `mem_wb_state`  out  `mem_wb`  MEM/WB register contents: valid, inst, inst_pc, op, inst_counter, reg_write_enable, reg_dest_addr, reg_write_data.
- `forward`  out  `reg_writer`  bypass to EX.
- `ok`  out  1  stage result is final this cycle.
- `dreq_valid`  out  1  data request valid.
- `dreq_addr`  out  64  byte address = `alu_result`.
- `dreq_size`  out  3  `msize_t` (MSIZE1/2/4/8).
- `dreq_strobe`  out  8  byte write enables; 0 for loads.
- `dreq_data`  out  64  store data, lane-shifted.
- `dresp_addr_ok`  in  1  ignored except by the assertion that valid is held.
- `dresp_data_ok`  in  1  access complete.
- `dresp_data`  in  64  raw read data (aligned doubleword).

Behaviour:
- Reset (`rst_n`=0 at edge):
  - State goes to IDLE; `load_buf` clears to 0.
  - Outputs then: `dreq_valid`=0, `ok`=1, `forward.reg_write_enable`=0.
  - Applies mid-access; an abandoned dbus transaction is dropped.
- `mem_op` = `ex_mem_state.valid` && op is load or store.
- FSM states and transitions:
  - IDLE: if `mem_op`, drive request, then go to WAIT. If `dresp_data_ok` arrives in the same cycle, capture the data and go to DONE instead.
  - WAIT: hold `dreq_valid`=1 with all dreq fields stable, taken from `ex_mem_state`, which is frozen because `ok`=0. On `dresp_data_ok`, capture data into `load_buf` and go to DONE.
  - DONE: `ok`=1, `dreq_valid`=0. On `step`, go to IDLE. Without `step`, stay in DONE and never reissue.
- `ok` values:
  - 1 when `!mem_op` in IDLE (zero latency, pure passthrough).
  - 0 in IDLE with `mem_op` and in WAIT.
  - 1 in DONE.
- Minimum load/store latency is 1 cycle beyond EX; one extra cycle per dbus wait state.
- Store lanes:
  - `dreq_strobe` = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - `dreq_data` = `write_mem_data` << (8*addr[2:0]).
- Load extraction:
  - raw = `dresp_data` >> (8*addr[2:0]), truncated to size.
  - LB/LH/LW/LD are sign-extended; LBU/LHU/LWU are zero-extended.
- Writeback data:
  - `reg_write_data` = extended load data for loads, otherwise `alu_result`.
  - For JAL/JALR, `alu_result` already holds pc+4.
- Write enable:
  - `reg_write_enable` = valid && op writes rd (arith/load/jump/lui/auipc) && rd != 0.
  - Stores and branches: 0.
- Register destination: `reg_dest_addr` = inst[11:7].
- Forward path: `forward` mirrors the `mem_wb` write fields, but `reg_write_enable` is forced to 0 while `ok`=0. A stale load is never bypassed.
- Passthrough fields: `mem_wb.valid`, inst, inst_pc, op and inst_counter pass through unchanged.
- Misalignment: out-of-scope. The request is issued as-is; the bus handles it.

Optional Feature:
- Macro: `MEM_STALL_COUNT_EN`.
- When defined:
  - Adds output `stall_cycles` (64-bit).
  - Increments every cycle with `ok`=0; cleared by reset only; wraps modulo 2^64.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- `common`: `msize_t` and its MSIZE constants, `word_t`, `strobe_t`.
- `temp_storage`: `mem_wb` struct.
- `combined_wire`: `reg_writer` (existing), `dbus_req_t`/`dbus_resp_t` if bundled.
- FSM state enum stays local to this module.
- Sub-module `mem_align` (combinational): op, addr[2:0], store data, raw read data → size, strobe, shifted store data, extended load data. Owns all lane logic.

Test Plan:
- ADD with `alu_result`=0x1234, rd=5 → `ok`=1 the same cycle; `dreq_valid`=0; `forward` = {1, 5, 0x1234}.
- LB at addr 0x80000003, `dresp_data`=0x00000000_80FF0000, `data_ok` after 2 wait cycles:
  - `ok`=0 for 2 cycles, with `forward.reg_write_enable`=0 during that time.
  - Result 0xFFFFFFFF_FFFFFF80; LBU gives 0x80.
- SH at addr 0x6, `write_mem_data`=0xABCD → `dreq_strobe`=0xC0, `dreq_data`=0xABCD0000_00000000, `reg_write_enable`=0.
- LD completes with `step`=0 for 3 cycles:
  - Stays in DONE with `ok`=1; `dreq_valid` stays 0.
  - Data is stable at 0x0123456789ABCDEF; the state reaches IDLE after the first `step`.
- `rst_n`=0 asserted during WAIT → next cycle `dreq_valid`=0, `ok`=1, state IDLE; the `dresp_data_ok` that arrives afterwards is ignored.
- Load to rd=0 → access is performed, `reg_write_enable`=0.
